// File: rtl/mips_bus_pkg.sv
// Shared types and widths for the MIPS Avalon-MM bus arbiter.
package mips_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mips_bus_mux.sv
// Combinational 2:1 request-bundle selector; drives an all-zero bundle when nothing is routed.
module mips_bus_mux
  import mips_bus_pkg::*;
(
  input  logic              sel,
  input  logic              valid,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable
);

  always_comb begin
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    if (valid) begin
      // A simultaneous read+write from one master is treated as a write.
      if (sel) begin
        s_address    = m1_address;
        s_read       = m1_read & ~m1_write;
        s_write      = m1_write;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
      end else begin
        s_address    = m0_address;
        s_read       = m0_read & ~m0_write;
        s_write      = m0_write;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
      end
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin Avalon-MM arbiter with zero-latency grant from idle.
// Optional burst locking (m0_lock/m1_lock, LOCK_MAX) is enabled by defining MIPS_ARB_LOCK_EN.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MIPS_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              owner,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic              dbg_last
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       req0, req1, own_live, routed, sel;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign own_live = (state_q == ARB_OWN0 && req0) || (state_q == ARB_OWN1 && req1);

  // Owner that dropped its request falls through to idle-style selection in the same cycle.
  always_comb begin
    routed = 1'b0;
    sel    = 1'b0;
    if (rst_n) begin
      if (own_live) begin
        routed = 1'b1;
        sel    = (state_q == ARB_OWN1);
      end else if (req0 || req1) begin
        routed = 1'b1;
        sel    = (req0 && req1) ? ~last_q : req1;
      end
    end
  end

  mips_bus_mux u_mux (
    .sel          (sel),
    .valid        (routed),
    .m0_address   (m0_address),
    .m0_read      (m0_read),
    .m0_write     (m0_write),
    .m0_writedata (m0_writedata),
    .m0_byteenable(m0_byteenable),
    .m1_address   (m1_address),
    .m1_read      (m1_read),
    .m1_write     (m1_write),
    .m1_writedata (m1_writedata),
    .m1_byteenable(m1_byteenable),
    .s_address    (s_address),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_writedata  (s_writedata),
    .s_byteenable (s_byteenable)
  );

`ifdef MIPS_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d, cnt_base;
  logic             lock_sel;
  assign cnt_base = own_live ? lock_cnt_q : '0;
  assign lock_sel = sel ? m1_lock : m0_lock;
`else
  logic lock_max_unused;
  assign lock_max_unused = (LOCK_MAX > 0);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
`ifdef MIPS_ARB_LOCK_EN
    lock_cnt_d = '0;
`endif
    if (!routed) begin
      state_d = ARB_IDLE;
    end else if (s_waitrequest) begin
      state_d = sel ? ARB_OWN1 : ARB_OWN0;
`ifdef MIPS_ARB_LOCK_EN
      lock_cnt_d = cnt_base;
`endif
    end else begin
      last_d  = sel;
      state_d = ARB_IDLE;
`ifdef MIPS_ARB_LOCK_EN
      if (lock_sel && (int'(cnt_base) + 1 < LOCK_MAX)) begin
        state_d    = sel ? ARB_OWN1 : ARB_OWN0;
        lock_cnt_d = cnt_base + CNT_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
`ifdef MIPS_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef MIPS_ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign busy           = routed;
  assign owner          = routed & sel;
  assign m0_waitrequest = ~(routed & ~sel) | s_waitrequest;
  assign m1_waitrequest = ~(routed & sel) | s_waitrequest;
  assign m0_readdata    = s_readdata;
  assign m1_readdata    = s_readdata;
  assign dbg_state      = state_q;
  assign dbg_last       = last_q;

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master, one-slave arbiter for the Avalon-MM memory bus used by `mips_cpu_bus`. Master 0 is the CPU and master 1 is a secondary requester such as a program loader or DMA engine; both share one memory slave port. Arbitration is round-robin per transfer, and the arbiter adds no latency when the bus is idle. Ownership is held while the slave stalls with `waitrequest`.

## Interface
Parameters:
- `LOCK_MAX`, 16: maximum consecutive locked transfers before a forced release. Only used with `MIPS_ARB_LOCK_EN`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_address`, `m1_address`  in  32  master byte address.
- `m0_read`, `m1_read`  in  1  read request.
- `m0_write`, `m1_write`  in  1  write request.
- `m0_writedata`, `m1_writedata`  in  32  write data.
- `m0_byteenable`, `m1_byteenable`  in  4  byte lanes.
- `m0_waitrequest`, `m1_waitrequest`  out  1  stall to the master.
- `m0_readdata`, `m1_readdata`  out  32  `s_readdata` broadcast; valid only for the owner when its `waitrequest` = 0.
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable`  out  32/1/1/32/4  slave request.
- `s_waitrequest`  in  1  slave stall.
- `s_readdata`  in  32  slave read data; zero-latency, valid in the cycle `s_waitrequest` = 0.
- `owner`  out  1  index of the master currently routed; meaningful when `busy` = 1.
- `busy`  out  1  a master is routed to the slave this cycle.

## Operation
- Request: `mX_req` = `mX_read` | `mX_write`. If `mX_write` and `mX_read` are both asserted, write wins and read is masked.
- State is `ARB_IDLE`, `ARB_OWN0` or `ARB_OWN1`. Register `last` holds the index of the most recently completed master.
- **ARB_IDLE**, selection:
  - Only one master requests: select it.
  - Both request: select `!last`.
  - The selected master is routed to the slave combinationally in the same cycle.
- **ARB_IDLE**, outcome:
  - `s_waitrequest` = 0: the transfer completes, `last` <= sel, and state stays `ARB_IDLE`.
  - `s_waitrequest` = 1: state <= `ARB_OWNsel`.
- **ARB_OWNx**:
  - Master x is routed and receives `s_waitrequest`.
  - When `s_waitrequest` = 0, the transfer completes, `last` <= x, and state <= `ARB_IDLE`.
- Master x deasserting its request while in `ARB_OWNx` is a protocol violation. The arbiter returns to `ARB_IDLE`, no transfer completes, and `last` is unchanged.
- Non-routed master: `waitrequest` = 1 at all times.
- No master routed: all `s_*` outputs are 0 and `busy` = 0.
- Reset (`rst_n` = 0, asynchronous):
  - state = `ARB_IDLE`, `last` = 1, so m0 wins the first tie.
  - `s_read` = `s_write` = 0 and `m0_waitrequest` = `m1_waitrequest` = 1, forced combinationally for as long as `rst_n` = 0.
  - An in-flight transfer is abandoned.

## Timing
- No added latency: a request granted in `ARB_IDLE` is seen by the slave in the same cycle.
- A losing master waits at least until the cycle after the winner completes.
- Back-to-back contention alternates masters every transfer.
- All outputs are combinational from the state registers and the inputs. There is no combinational path from `s_waitrequest` to any `s_*` output.

## Configuration
- With `MIPS_ARB_LOCK_EN` defined:
  - Adds inputs `m0_lock` and `m1_lock` (1 bit each) and a `$clog2(LOCK_MAX+1)`-bit counter `lock_cnt`.
  - A transfer by owner x that completes with `mX_lock` = 1 keeps state at `ARB_OWNx` and increments `lock_cnt`.
  - When `lock_cnt` reaches `LOCK_MAX`, or on a completion with `mX_lock` = 0, state <= `ARB_IDLE` and `lock_cnt` <= 0.
  - In every case, completion sets `last` <= x.
- Without the macro: the lock ports and counter are absent, and every completion returns to `ARB_IDLE`.

## Structure
- Package `mips_bus_pkg`: `arb_state_t` enum (`ARB_IDLE`, `ARB_OWN0`, `ARB_OWN1`) and the width constants `ADDR_W` = 32, `DATA_W` = 32, `BE_W` = 4.
- Sub-module `mips_bus_mux`: combinational 2:1 selection of the address, read, write, writedata and byteenable bundle, driven by sel and a routed-valid signal.

## Test plan
- m0 reads 0x1000 alone with `s_waitrequest` = 0 -> `s_address` = 0x1000 in the same cycle; `m0_waitrequest` = 0; `m0_readdata` = `s_readdata`; `last` = 0.
- m0 and m1 request simultaneously after reset -> m0 is served first, m1 next; four back-to-back contended transfers are served in the order 0, 1, 0, 1.
- m1 writes 0xDEADBEEF with byteenable 0x3 and a 3-cycle slave stall -> state `ARB_OWN1` for 3 cycles; m0 stays stalled; `s_writedata` is held; completion in cycle 4.
- `rst_n` pulsed low mid-stall -> `s_read` and `s_write` drop immediately; both waitrequests = 1; after release, a tie grants m0.
- `MIPS_ARB_LOCK_EN` with `LOCK_MAX` = 4: m1 holds `m1_lock` = 1 with both masters requesting -> 4 m1 transfers, then m0 is granted.
- m0 drops `read` while stalled in `ARB_OWN0` -> return to `ARB_IDLE` with `last` unchanged; a pending m1 request is granted that cycle.
